// File: rtl/pipeline_fetch_stage.sv
// IF stage: owns the PC and the IF/ID register, and drives the instruction ROM address.
// Stall beats redirect, redirect beats halt, and halt beats normal fetch.
module pipeline_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          ROM_ADDR_W = 5,
   parameter int          ROM_DEPTH  = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   output logic [ROM_ADDR_W-1:0] o_imem_addr,
   input  logic [31:0]           i_imem_rdata,
   input  logic                  i_stall,
   input  logic                  i_redirect,
   input  logic [31:0]           i_redirect_pc,
   output logic [31:0]           o_pc,
   output logic [31:0]           o_id_instr,
   output logic [31:0]           o_id_pc_plus4,
   output logic                  o_id_valid,
   output logic                  o_halted,
   output logic [31:0]           o_fetch_count
);

   localparam logic [29:0] DEPTH_WORDS = 30'(ROM_DEPTH);

   logic [31:0] r_pc;
   logic [31:0] r_id_instr;
   logic [31:0] r_id_pc_plus4;
   logic        r_id_valid;
   logic        r_halted;
   logic [31:0] r_fetch_count;

   logic [31:0] w_pc_nxt;
   logic [31:0] w_id_instr_nxt;
   logic [31:0] w_id_pc_plus4_nxt;
   logic        w_id_valid_nxt;
   logic        w_halted_nxt;
   logic [31:0] w_fetch_count_nxt;
   logic [31:0] w_pc_plus4;
   logic        w_end;

   // The end test looks at the full word index, so addresses that alias inside the ROM still halt.
   assign w_end       = (r_pc[31:2] >= DEPTH_WORDS);
   assign w_pc_plus4  = r_pc + 32'd4;
   assign o_imem_addr = r_pc[ROM_ADDR_W+1:2];

   // Next-state selection for the PC, the IF/ID register, the halt flag and the fetch counter.
   always_comb begin
      w_pc_nxt          = r_pc;
      w_id_instr_nxt    = r_id_instr;
      w_id_pc_plus4_nxt = r_id_pc_plus4;
      w_id_valid_nxt    = r_id_valid;
      w_halted_nxt      = r_halted;
      w_fetch_count_nxt = r_fetch_count;
      if (i_stall) begin
         w_pc_nxt = r_pc;
      end else if (i_redirect) begin
         w_pc_nxt          = {i_redirect_pc[31:2], 2'b00};
         w_id_instr_nxt    = 32'h0000_0000;
         w_id_pc_plus4_nxt = 32'h0000_0000;
         w_id_valid_nxt    = 1'b0;
         w_halted_nxt      = 1'b0;
      end else if (r_halted || w_end) begin
         w_id_instr_nxt    = 32'h0000_0000;
         w_id_pc_plus4_nxt = 32'h0000_0000;
         w_id_valid_nxt    = 1'b0;
         w_halted_nxt      = 1'b1;
      end else begin
         w_pc_nxt          = w_pc_plus4;
         w_id_instr_nxt    = i_imem_rdata;
         w_id_pc_plus4_nxt = w_pc_plus4;
         w_id_valid_nxt    = 1'b1;
         if (r_fetch_count != 32'hFFFF_FFFF) begin
            w_fetch_count_nxt = r_fetch_count + 32'd1;
         end else begin
            w_fetch_count_nxt = r_fetch_count;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pc          <= RESET_PC;
         r_id_instr    <= 32'h0000_0000;
         r_id_pc_plus4 <= 32'h0000_0000;
         r_id_valid    <= 1'b0;
         r_halted      <= 1'b0;
         r_fetch_count <= 32'h0000_0000;
      end else begin
         r_pc          <= w_pc_nxt;
         r_id_instr    <= w_id_instr_nxt;
         r_id_pc_plus4 <= w_id_pc_plus4_nxt;
         r_id_valid    <= w_id_valid_nxt;
         r_halted      <= w_halted_nxt;
         r_fetch_count <= w_fetch_count_nxt;
      end
   end

   assign o_pc          = r_pc;
   assign o_id_instr    = r_id_instr;
   assign o_id_pc_plus4 = r_id_pc_plus4;
   assign o_id_valid    = r_id_valid;
   assign o_halted      = r_halted;
   assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Bench for pipeline_fetch_stage: directed scenarios followed by random stall/redirect/reset traffic.
// The reference model is a cycle-level transcription of the fetch rules written in plain arithmetic.
module tb_pipeline_fetch_stage;

   localparam int DEPTH = 8;
   localparam int AW    = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata;
   logic          stall;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic [31:0]   pc;
   logic [31:0]   id_instr;
   logic [31:0]   id_pc_plus4;
   logic          id_valid;
   logic          halted;
   logic [31:0]   fetch_count;

   logic [31:0] rom [32];

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pp4;
   logic        m_valid;
   logic        m_halt;
   logic [31:0] m_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign imem_rdata = rom[imem_addr];

   pipeline_fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .ROM_ADDR_W(AW),
      .ROM_DEPTH (DEPTH)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .o_imem_addr  (imem_addr),
      .i_imem_rdata (imem_rdata),
      .i_stall      (stall),
      .i_redirect   (redirect),
      .i_redirect_pc(redirect_pc),
      .o_pc         (pc),
      .o_id_instr   (id_instr),
      .o_id_pc_plus4(id_pc_plus4),
      .o_id_valid   (id_valid),
      .o_halted     (halted),
      .o_fetch_count(fetch_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("pc", pc, m_pc);
      chk("imem_addr", {27'd0, imem_addr}, (m_pc >> 2) & 32'd31);
      chk("id_instr", id_instr, m_instr);
      chk("id_pc_plus4", id_pc_plus4, m_pp4);
      chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
      chk("halted", {31'd0, halted}, {31'd0, m_halt});
      chk("fetch_count", fetch_count, m_cnt);
   endtask

   // One clock: drive inputs, advance the model by the fetch rules, then compare after the edge.
   task automatic cyc(input logic r, input logic s, input logic d, input logic [31:0] tgt);
      logic [31:0] n_pc, n_instr, n_pp4, n_cnt;
      logic        n_valid, n_halt;
      rst_n = r; stall = s; redirect = d; redirect_pc = tgt;
      n_pc = m_pc; n_instr = m_instr; n_pp4 = m_pp4;
      n_valid = m_valid; n_halt = m_halt; n_cnt = m_cnt;
      if (!r) begin
         n_pc = 32'h0; n_instr = 32'h0; n_pp4 = 32'h0; n_valid = 1'b0; n_halt = 1'b0; n_cnt = 32'h0;
      end else if (s) begin
         n_pc = m_pc;
      end else if (d) begin
         n_pc = tgt & 32'hFFFF_FFFC;
         n_instr = 32'h0; n_pp4 = 32'h0; n_valid = 1'b0; n_halt = 1'b0;
      end else if (m_halt || ((m_pc / 4) >= DEPTH)) begin
         n_instr = 32'h0; n_pp4 = 32'h0; n_valid = 1'b0; n_halt = 1'b1;
      end else begin
         n_instr = rom[(m_pc / 4) % 32];
         n_pp4   = m_pc + 32'd4;
         n_pc    = m_pc + 32'd4;
         n_valid = 1'b1;
         n_cnt   = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 32'd1;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4;
      m_valid = n_valid; m_halt = n_halt; m_cnt = n_cnt;
      check_all();
   endtask

   initial begin
      logic [31:0] tgt;
      for (int i = 0; i < 32; i++) rom[i] = $urandom();
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_halt = 1'b0; m_cnt = 32'h0;

      // Reset
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);

      // Straight-line run to the end of the ROM, then halt
      repeat (DEPTH) cyc(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t1_count", fetch_count, 32'd8);
      chk("t1_last_instr", id_instr, rom[7]);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t1_halted", {31'd0, halted}, 32'd1);
      chk("t1_pc_hold", pc, 32'h20);
      chk("t1_bubble", id_instr, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t1_pc_hold2", pc, 32'h20);

      // Redirect out of halt
      cyc(1'b1, 1'b0, 1'b1, 32'h4);
      chk("t5_unhalt", {31'd0, halted}, 32'd0);
      chk("t5_pc", pc, 32'h4);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t5_instr", id_instr, rom[1]);
      chk("t5_valid", {31'd0, id_valid}, 32'd1);

      // Stall at pc=8
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'h0);
      chk("t2_pc", pc, 32'h8);
      chk("t2_instr", id_instr, rom[1]);
      chk("t2_count", fetch_count, 32'd9);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t2_resume", id_instr, rom[2]);

      // Redirect to an unaligned target at pc=C
      cyc(1'b1, 1'b0, 1'b1, 32'h0000_0015);
      chk("t3_pc", pc, 32'h14);
      chk("t3_bubble", {31'd0, id_valid}, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t3_instr", id_instr, rom[5]);

      // Reset mid-program at pc=18
      chk("t6_pre_pc", pc, 32'h18);
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t6_pc", pc, 32'h0);
      chk("t6_count", fetch_count, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      chk("t6_instr", id_instr, rom[0]);

      // Stall and redirect together, then redirect alone
      cyc(1'b1, 1'b1, 1'b1, 32'h1C);
      chk("t4_hold", pc, 32'h4);
      cyc(1'b1, 1'b0, 1'b1, 32'h1C);
      chk("t4_jump", pc, 32'h1C);

      // Redirect to the top of the address space halts immediately
      cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
      chk("wrap_pc", pc, 32'hFFFF_FFFC);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      chk("wrap_halt", {31'd0, halted}, 32'd1);
      chk("wrap_count", fetch_count, 32'd1);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         tgt = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 4 * DEPTH + 8));
         cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 4) == 0), tgt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
